aes_lane_frontend: RTL and testbench
====================================

Name: aes_lane_frontend

Overview:
- Parametrised successor of the AES frontend.
- Latches a wide plaintext buffer on `start` and splits it into 128-bit blocks.
- Dispatches blocks round-robin to LANES AES cores over valid/ready, collects results per lane in order, and stitches them back into a registered output buffer.
- Sits between the host buffer and the AES core array.

Parameters:
- BUF_BITS, 4096, total buffer width; must be a multiple of BLK_BITS*LANES.
- BLK_BITS, 128, AES block width; fixed by the package.
- LANES, 4, number of parallel AES cores.
- Derived: NUM_BLKS = BUF_BITS/BLK_BITS (32); PER_LANE = NUM_BLKS/LANES (8).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle job request; sampled only in IDLE.
- din  in  BUF_BITS  input buffer; block i = din[i*BLK_BITS +: BLK_BITS].
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when dout is complete.
- overrun  out  1  sticky error: unexpected core result.
- dout  out  BUF_BITS  stitched result buffer.
- core_in_valid  out  LANES  per-lane block valid.
- core_in_ready  in  LANES  per-lane core accept.
- core_in_data  out  LANES*BLK_BITS  lane l data at [l*BLK_BITS +: BLK_BITS].
- core_out_valid  in  LANES  per-lane result valid.
- core_out_data  in  LANES*BLK_BITS  per-lane result.
- core_out_ready  out  LANES  per-lane result accept.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy=0, done=0, overrun=0; dout=0; core_in_valid=0; core_out_ready=0; all counters 0.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: on start=1, latch din into the input register, clear issue/return counters, clear overrun, go to RUN next cycle.
  - DONE: lasts exactly one cycle; done=1, busy=0.
- Block-to-lane mapping: block i goes to lane i%LANES as that lane's (i/LANES)-th transfer.
- Issue, per lane l in RUN:
  - core_in_valid[l]=1 while issue_cnt[l] < PER_LANE.
  - core_in_data[l] = block (l + issue_cnt[l]*LANES).
  - A transfer occurs when valid&ready; issue_cnt[l] increments.
  - Data is held stable while valid and not ready.
- Return, per lane l in RUN:
  - core_out_ready[l]=1 while ret_cnt[l] < PER_LANE.
  - On valid&ready, write core_out_data[l] into dout block (l + ret_cnt[l]*LANES); ret_cnt[l] increments.
  - Lanes proceed independently; completion order across lanes is arbitrary.
- Completion: when every ret_cnt == PER_LANE, go to DONE on the next edge. dout holds until the next job's first write.
- Latency with zero-latency, always-ready cores returning one cycle after issue: start -> done = PER_LANE + 3 cycles (11 at defaults).
- Boundary conditions:
  - start in RUN or DONE: ignored.
  - Issue and return on the same lane in the same cycle: both counters update.
  - core_out_valid[l]=1 when ret_cnt[l]==PER_LANE in RUN, or any core_out_valid in IDLE: data dropped, overrun=1 (sticky until next accepted start or reset).
  - rst_n low mid-job: immediate return to reset values; results arriving later are handled as in IDLE.

Optional Feature:
- Macro AES_FRONTEND_PERF_EN.
- Defined: adds output perf_cycles[15:0], reset 0.
  - Counts cycles spent in RUN for the current job; frozen at the DONE cycle until the next start.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package aes_frontend_pkg:
  - localparam BLK_BITS=128.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} fe_state_t.
  - typedef logic [BLK_BITS-1:0] aes_blk_t.
- Sub-module aes_frontend_lane, instanced LANES times:
  - Holds issue_cnt/ret_cnt and the valid/ready logic for one lane.
  - Produces block-index outputs for the top-level mux/demux.
  - Reports lane_done and lane_overrun.

Test Plan:
- Identity cores (result = input, always ready, 1-cycle): din = block i holds 128'(i) -> dout == din, done pulses once exactly 11 cycles after start, overrun=0.
- Inverting cores with lane 2 stalled (ready=0) for 20 cycles -> dout == ~din, lane 2 data stable during the stall, done only after lane 2's 8th result.
- Out-of-order lanes (lane 3 answers first, lane 0 last) -> every block lands at index l+k*LANES; dout correct.
- start pulsed again in RUN -> ignored; din changed mid-job does not affect results.
- Extra core_out_valid on lane 1 after its 8 results -> overrun=1 and dout unchanged; next start clears overrun.
- rst_n low in the 5th RUN cycle -> all outputs at reset values asynchronously; a fresh job afterwards completes correctly. With AES_FRONTEND_PERF_EN, perf_cycles == 9 for the identity-core job.

Source files
------------

// File: rtl/aes_frontend_pkg.sv
// Shared types for the AES lane frontend: block width, FSM encoding and the
// block type used on every core interface.
package aes_frontend_pkg;

    localparam int BLK_BITS = 128;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fe_state_t;

    typedef logic [BLK_BITS-1:0] aes_blk_t;

endpackage

// File: rtl/aes_frontend_lane.sv
// One lane of the AES frontend: tracks how many blocks this lane has issued
// and how many results it has taken back, and turns those counts into the
// block indices the top level uses to mux input data and place results.
module aes_frontend_lane #(
    parameter int LANE     = 0,
    parameter int LANES    = 4,
    parameter int PER_LANE = 8,
    parameter int IDX_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic             in_ready,
    input  logic             out_valid,
    output logic             in_valid,
    output logic             out_ready,
    output logic [IDX_W-1:0] issue_idx,
    output logic [IDX_W-1:0] ret_idx,
    output logic             lane_done,
    output logic             lane_overrun
);

    localparam int CNT_W = $clog2(PER_LANE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PER_LANE);

    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] ret_cnt;

    // Issue and return counters advance independently, both in the same cycle if needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (clear) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (in_valid && in_ready) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (out_valid && out_ready) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end

    // Block k of this lane is global block LANE + k*LANES.
    always_comb begin
        in_valid     = run && (issue_cnt < CNT_MAX);
        out_ready    = run && (ret_cnt < CNT_MAX);
        issue_idx    = IDX_W'(LANE) + IDX_W'(issue_cnt) * IDX_W'(LANES);
        ret_idx      = IDX_W'(LANE) + IDX_W'(ret_cnt) * IDX_W'(LANES);
        lane_done    = (ret_cnt == CNT_MAX);
        // Any result we are not ready for is unexpected: lane already full, or not running.
        lane_overrun = out_valid && !out_ready;
    end

endmodule

// File: rtl/aes_lane_frontend.sv
// AES lane frontend: latches a wide plaintext buffer on start, deals its
// 128-bit blocks round-robin to LANES cores, and stitches results back into
// dout. Optional macro AES_FRONTEND_PERF_EN adds a perf_cycles run counter.
//
// state | meaning
// IDLE  | waiting for start; stray core results flag overrun
// RUN   | issuing blocks and collecting results on all lanes
// DONE  | one-cycle completion pulse, dout complete
module aes_lane_frontend
    import aes_frontend_pkg::*;
#(
    parameter int BUF_BITS = 4096,
    parameter int LANES    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BUF_BITS-1:0]       din,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    output logic [BUF_BITS-1:0]       dout,
`ifdef AES_FRONTEND_PERF_EN
    output logic [15:0]               perf_cycles,
`endif
    output logic [LANES-1:0]          core_in_valid,
    input  logic [LANES-1:0]          core_in_ready,
    output logic [LANES*BLK_BITS-1:0] core_in_data,
    input  logic [LANES-1:0]          core_out_valid,
    input  logic [LANES*BLK_BITS-1:0] core_out_data,
    output logic [LANES-1:0]          core_out_ready
);

    localparam int NUM_BLKS = BUF_BITS / BLK_BITS;
    localparam int PER_LANE = NUM_BLKS / LANES;
    localparam int IDX_W    = (NUM_BLKS > 1) ? $clog2(NUM_BLKS) : 1;

    fe_state_t state_q;
    fe_state_t state_d;

    logic                start_acc;
    logic                run;
    logic [BUF_BITS-1:0] din_q;
    logic [LANES-1:0]    lane_done;
    logic [LANES-1:0]    lane_overrun;
    logic [IDX_W-1:0]    issue_idx [LANES];
    logic [IDX_W-1:0]    ret_idx   [LANES];

    assign run = (state_q == RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; start is only honoured in IDLE.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (&lane_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Input snapshot; din may change freely once a job is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= '0;
        end else if (start_acc) begin
            din_q <= din;
        end
    end

    // Sticky overrun, cleared only by an accepted start (or reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (start_acc) begin
            overrun <= 1'b0;
        end else if (|lane_overrun) begin
            overrun <= 1'b1;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_frontend_lane #(
            .LANE     (l),
            .LANES    (LANES),
            .PER_LANE (PER_LANE),
            .IDX_W    (IDX_W)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear        (start_acc),
            .run          (run),
            .in_ready     (core_in_ready[l]),
            .out_valid    (core_out_valid[l]),
            .in_valid     (core_in_valid[l]),
            .out_ready    (core_out_ready[l]),
            .issue_idx    (issue_idx[l]),
            .ret_idx      (ret_idx[l]),
            .lane_done    (lane_done[l]),
            .lane_overrun (lane_overrun[l])
        );
    end

    // Input mux: each lane presents the block selected by its issue count.
    always_comb begin
        core_in_data = '0;
        for (int l = 0; l < LANES; l++) begin
            core_in_data[l*BLK_BITS +: BLK_BITS] = din_q[int'(issue_idx[l])*BLK_BITS +: BLK_BITS];
        end
    end

    // Result demux: accepted results land in their block slot; dout is not
    // cleared on start so it holds until overwritten by the next job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (core_out_valid[l] && core_out_ready[l]) begin
                    dout[int'(ret_idx[l])*BLK_BITS +: BLK_BITS] <= core_out_data[l*BLK_BITS +: BLK_BITS];
                end
            end
        end
    end

`ifdef AES_FRONTEND_PERF_EN
    // Run-cycle counter: counts working RUN cycles, stops once all lanes are
    // complete so the value is frozen through DONE, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
        end else if (run && !(&lane_done) && (perf_cycles != 16'hFFFF)) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_lane_frontend.sv
// Directed bench for aes_lane_frontend with a behavioural core array model
// (identity or inverting, per-lane input stall, per-lane output enable and
// spurious-result injection).
module tb_aes_lane_frontend;
    import aes_frontend_pkg::*;

    localparam int BUF_BITS = 4096;
    localparam int LANES    = 4;
    localparam int NUM_BLKS = 32;
    localparam int PER_LANE = 8;
    localparam logic [127:0] INJ_DATA = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      start;
    logic [BUF_BITS-1:0]       din;
    logic                      busy;
    logic                      done;
    logic                      overrun;
    logic [BUF_BITS-1:0]       dout;
`ifdef AES_FRONTEND_PERF_EN
    logic [15:0]               perf_cycles;
`endif
    logic [LANES-1:0]          core_in_valid;
    logic [LANES-1:0]          core_in_ready;
    logic [LANES*BLK_BITS-1:0] core_in_data;
    logic [LANES-1:0]          core_out_valid;
    logic [LANES*BLK_BITS-1:0] core_out_data;
    logic [LANES-1:0]          core_out_ready;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    aes_lane_frontend #(.BUF_BITS(BUF_BITS), .LANES(LANES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .din            (din),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun),
        .dout           (dout),
`ifdef AES_FRONTEND_PERF_EN
        .perf_cycles    (perf_cycles),
`endif
        .core_in_valid  (core_in_valid),
        .core_in_ready  (core_in_ready),
        .core_in_data   (core_in_data),
        .core_out_valid (core_out_valid),
        .core_out_data  (core_out_data),
        .core_out_ready (core_out_ready)
    );

    // Core array model: results become visible the cycle after acceptance.
    logic [LANES-1:0] in_rdy;
    logic [LANES-1:0] out_en;
    logic [LANES-1:0] inj;
    logic             invert;
    logic [127:0]     res_mem [LANES][16];
    int               wr_ptr [LANES];
    int               rd_ptr [LANES];

    assign core_in_ready = in_rdy;

    always_comb begin
        core_out_valid = '0;
        core_out_data  = '0;
        for (int l = 0; l < LANES; l++) begin
            core_out_valid[l] = inj[l] || (out_en[l] && (wr_ptr[l] != rd_ptr[l]));
            core_out_data[l*128 +: 128] = inj[l] ? INJ_DATA : res_mem[l][rd_ptr[l] & 15];
        end
    end

    always @(posedge clk) begin : core_model
        logic [LANES-1:0] pop;
        logic [LANES-1:0] push;
        logic [127:0]     pd [LANES];
        for (int l = 0; l < LANES; l++) begin
            pop[l]  = core_out_valid[l] && core_out_ready[l] && !inj[l];
            push[l] = core_in_valid[l] && core_in_ready[l];
            pd[l]   = invert ? ~core_in_data[l*128 +: 128] : core_in_data[l*128 +: 128];
        end
        #1;
        for (int l = 0; l < LANES; l++) begin
            if (push[l]) begin
                res_mem[l][wr_ptr[l] & 15] = pd[l];
                wr_ptr[l] = wr_ptr[l] + 1;
            end
            if (pop[l]) rd_ptr[l] = rd_ptr[l] + 1;
        end
    end

    function automatic logic [BUF_BITS-1:0] mk_id();
        logic [BUF_BITS-1:0] b;
        for (int i = 0; i < NUM_BLKS; i++) b[i*128 +: 128] = 128'(i);
        return b;
    endfunction

    function automatic logic [BUF_BITS-1:0] mk_buf(input int seed);
        logic [BUF_BITS-1:0] b;
        for (int i = 0; i < NUM_BLKS; i++)
            b[i*128 +: 128] = {(32'(seed) * 32'h9E37_79B9) ^ 32'(i), 32'(i),
                               32'hA5A5_0000 + 32'(seed), 32'(i * 3 + seed)};
        return b;
    endfunction

    function automatic int first_bad_blk(input logic [BUF_BITS-1:0] a, input logic [BUF_BITS-1:0] b);
        for (int i = 0; i < NUM_BLKS; i++)
            if (a[i*128 +: 128] !== b[i*128 +: 128]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int l = 0; l < LANES; l++) begin
            wr_ptr[l] = 0;
            rd_ptr[l] = 0;
        end
        inj = '0;
    endtask

    // Raise start for one cycle; returns at #1 after the sampling edge (latency 1).
    task automatic pulse_start(input logic [BUF_BITS-1:0] d);
        @(posedge clk);
        #1;
        din   = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Latency counted in cycles from the cycle start was raised.
    task automatic wait_done(input int budget, output int lat);
        lat = 1;
        while (!done && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        din    = '0;
        in_rdy = '1;
        out_en = '1;
        invert = 1'b0;
        model_clear();
        #12;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passes++;
        checks++; if (dout !== '0) $display("FAIL reset_dout: first nonzero block %0d", first_bad_blk(dout, '0)); else passes++;
        checks++; if (core_in_valid !== 4'b0) $display("FAIL reset_in_valid: got %b expected 0000", core_in_valid); else passes++;
        checks++; if (core_out_ready !== 4'b0) $display("FAIL reset_out_ready: got %b expected 0000", core_out_ready); else passes++;
`ifdef AES_FRONTEND_PERF_EN
        checks++; if (perf_cycles !== 16'd0) $display("FAIL reset_perf: got %0d expected 0", perf_cycles); else passes++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        logic [BUF_BITS-1:0] exp;
        int lat;
        model_clear();
        invert = 1'b0;
        exp = mk_id();
        pulse_start(exp);
        wait_done(40, lat);
        checks++; if (lat != 11) $display("FAIL id_latency: got %0d expected 11", lat); else passes++;
        checks++; if (dout !== exp) $display("FAIL id_dout: first bad block %0d got %h expected %h",
            first_bad_blk(dout, exp), dout[0 +: 128], exp[0 +: 128]); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL id_overrun: got %b expected 0", overrun); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL id_busy_in_done: got %b expected 0", busy); else passes++;
`ifdef AES_FRONTEND_PERF_EN
        checks++; if (perf_cycles !== 16'd9) $display("FAIL id_perf: got %0d expected 9", perf_cycles); else passes++;
`endif
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) $display("FAIL id_done_pulse: got %b expected 0", done); else passes++;
    endtask

    task automatic test_stall();
        logic [BUF_BITS-1:0] d;
        int bad_hold, early_done, lat;
        model_clear();
        invert    = 1'b1;
        in_rdy[2] = 1'b0;
        d = mk_buf(1);
        pulse_start(d);
        bad_hold   = 0;
        early_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (!core_in_valid[2] || core_in_data[2*128 +: 128] !== d[2*128 +: 128]) bad_hold++;
            if (done) early_done++;
            @(posedge clk);
            #1;
        end
        checks++; if (bad_hold != 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad_hold); else passes++;
        checks++; if (early_done != 0) $display("FAIL stall_early_done: got %0d done cycles expected 0", early_done); else passes++;
        in_rdy = '1;
        wait_done(60, lat);
        checks++; if (lat < 0) $display("FAIL stall_timeout: got no done expected done"); else passes++;
        checks++; if (rd_ptr[2] != PER_LANE) $display("FAIL stall_lane2_results: got %0d expected %0d", rd_ptr[2], PER_LANE); else passes++;
        checks++; if (dout !== ~d) $display("FAIL stall_dout: first bad block %0d", first_bad_blk(dout, ~d)); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL stall_overrun: got %b expected 0", overrun); else passes++;
        invert = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ooo();
        logic [BUF_BITS-1:0] d, part;
        int lat;
        model_clear();
        out_en = 4'b1000;
        d    = mk_buf(2);
        part = ~mk_buf(1);
        for (int k = 0; k < PER_LANE; k++) part[(3 + k*LANES)*128 +: 128] = d[(3 + k*LANES)*128 +: 128];
        pulse_start(d);
        repeat (12) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL ooo_still_busy: got busy=%b done=%b expected 1/0", busy, done); else passes++;
        checks++; if (dout !== part) $display("FAIL ooo_lane3_first: first bad block %0d", first_bad_blk(dout, part)); else passes++;
        out_en[2] = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        out_en[1] = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        out_en[0] = 1'b1;
        wait_done(60, lat);
        checks++; if (lat < 0) $display("FAIL ooo_timeout: got no done expected done"); else passes++;
        checks++; if (dout !== d) $display("FAIL ooo_dout: first bad block %0d", first_bad_blk(dout, d)); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL ooo_overrun: got %b expected 0", overrun); else passes++;
    endtask

    task automatic test_restart_ignored();
        logic [BUF_BITS-1:0] d;
        int lat, extra_done;
        model_clear();
        d = mk_buf(3);
        pulse_start(d);
        repeat (2) begin @(posedge clk); #1; end
        din   = mk_buf(4);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        // four cycles elapsed before this loop (1 from pulse_start, 2 waits, 1 restart pulse)
        checks++; if (lat + 4 != 11) $display("FAIL restart_latency: got %0d expected 11", lat + 4); else passes++;
        checks++; if (dout !== d) $display("FAIL restart_dout: first bad block %0d", first_bad_blk(dout, d)); else passes++;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || core_in_valid !== 4'b0) $display("FAIL start_in_done: got busy=%b valid=%b expected 0/0000", busy, core_in_valid); else passes++;
        extra_done = 0;
        repeat (15) begin @(posedge clk); #1; if (done || busy) extra_done++; end
        checks++; if (extra_done != 0) $display("FAIL restart_no_second_job: got %0d active cycles expected 0", extra_done); else passes++;
    endtask

    task automatic test_overrun();
        logic [BUF_BITS-1:0] d, d2, exp;
        int lat;
        model_clear();
        out_en = 4'b0010;
        d   = mk_buf(5);
        exp = mk_buf(3);
        for (int k = 0; k < PER_LANE; k++) exp[(1 + k*LANES)*128 +: 128] = d[(1 + k*LANES)*128 +: 128];
        pulse_start(d);
        repeat (11) begin @(posedge clk); #1; end
        checks++; if (overrun !== 1'b0) $display("FAIL ovr_before: got %b expected 0", overrun); else passes++;
        inj[1] = 1'b1;
        @(posedge clk);
        #1;
        inj[1] = 1'b0;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_run_set: got %b expected 1", overrun); else passes++;
        checks++; if (dout !== exp) $display("FAIL ovr_dout_unchanged: first bad block %0d", first_bad_blk(dout, exp)); else passes++;
        out_en = '1;
        wait_done(60, lat);
        checks++; if (lat < 0) $display("FAIL ovr_timeout: got no done expected done"); else passes++;
        checks++; if (dout !== d) $display("FAIL ovr_dout: first bad block %0d", first_bad_blk(dout, d)); else passes++;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", overrun); else passes++;
        model_clear();
        d2 = mk_buf(6);
        pulse_start(d2);
        checks++; if (overrun !== 1'b0) $display("FAIL ovr_cleared_by_start: got %b expected 0", overrun); else passes++;
        wait_done(40, lat);
        checks++; if (dout !== d2) $display("FAIL ovr_next_dout: first bad block %0d", first_bad_blk(dout, d2)); else passes++;
        @(posedge clk);
        #1;
        inj[0] = 1'b1;
        @(posedge clk);
        #1;
        inj[0] = 1'b0;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_idle_set: got %b expected 1", overrun); else passes++;
        checks++; if (dout !== d2) $display("FAIL ovr_idle_dout: first bad block %0d", first_bad_blk(dout, d2)); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [BUF_BITS-1:0] exp;
        int lat;
        model_clear();
        pulse_start(mk_buf(7));
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_status: got busy=%b done=%b expected 0/0", busy, done); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL rstmid_overrun: got %b expected 0", overrun); else passes++;
        checks++; if (dout !== '0) $display("FAIL rstmid_dout: first nonzero block %0d", first_bad_blk(dout, '0)); else passes++;
        checks++; if (core_in_valid !== 4'b0 || core_out_ready !== 4'b0) $display("FAIL rstmid_handshake: got valid=%b ready=%b expected 0000/0000", core_in_valid, core_out_ready); else passes++;
`ifdef AES_FRONTEND_PERF_EN
        checks++; if (perf_cycles !== 16'd0) $display("FAIL rstmid_perf: got %0d expected 0", perf_cycles); else passes++;
`endif
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        exp = mk_id();
        pulse_start(exp);
        wait_done(40, lat);
        checks++; if (lat != 11) $display("FAIL rstmid_job_latency: got %0d expected 11", lat); else passes++;
        checks++; if (dout !== exp) $display("FAIL rstmid_job_dout: first bad block %0d", first_bad_blk(dout, exp)); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL rstmid_job_overrun: got %b expected 0", overrun); else passes++;
`ifdef AES_FRONTEND_PERF_EN
        checks++; if (perf_cycles !== 16'd9) $display("FAIL rstmid_job_perf: got %0d expected 9", perf_cycles); else passes++;
`endif
    endtask

    initial begin
        inj = '0;
        test_reset();
        test_identity();
        test_stall();
        test_ooo();
        test_restart_ignored();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
